// File: rtl/dmem_stream_fp.sv
// dmem_stream_fp: DEPTH x DW data memory with a strided read-stream engine.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data      synchronous write port (works in any state)
//   start, base, len, stride     stream command, accepted only while idle
//   abort                        cancels an active stream at the next edge
//   out_valid/out_ready/out_data/out_last  valid/ready output stream
//   busy                         engine not idle
//   done                         one-cycle pulse after a stream completes
//
// Read k of a stream addresses (base + k*stride) mod DEPTH, produced by an
// accumulator with a conditional subtract. Reads take one cycle and land in a
// 2-entry output FIFO; a read issues only when that FIFO is guaranteed to
// have room for it, so nothing is ever dropped.
module dmem_stream_fp #(
  parameter int DW    = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] stride,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [DW-1:0] mem_q [DEPTH];

  state_e        state_q;
  logic [AW-1:0] addr_q, stride_q, addr_d;
  logic [AW:0]   len_q, iss_q, addr_sum_s;
  logic          rd_vld_q, rd_last_q;
  logic [DW-1:0] rd_data_q;
  logic [1:0]    cnt_q, cnt_d, occ_s;
  logic [DW-1:0] head_q, head_d, tail_q, tail_d;
  logic          head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic          valid_q, done_q, busy_q;
  logic          pop_s, issue_s, last_iss_s;

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign out_last  = head_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Handshake, issue credit and next stride address
  always_comb begin
    pop_s      = valid_q & out_ready;
    // Occupancy after this cycle's pop plus the read still in flight; a new
    // read is allowed only if it would still fit in the two FIFO slots.
    occ_s      = cnt_q - {1'b0, pop_s} + {1'b0, rd_vld_q};
    issue_s    = (state_q == RUN) && !abort && (occ_s < 2'd2);
    last_iss_s = (iss_q == (len_q - ONE_L));
    // base and stride are both < DEPTH, so one subtract keeps it in range.
    addr_sum_s = {1'b0, addr_q} + {1'b0, stride_q};
    if (addr_sum_s >= DEPTH_L) begin
      addr_d = AW'(addr_sum_s - DEPTH_L);
    end else begin
      addr_d = addr_sum_s[AW-1:0];
    end
  end

  // Output FIFO next state: head register drives the stream, tail is the spare
  always_comb begin
    cnt_d       = cnt_q;
    head_d      = head_q;
    head_last_d = head_last_q;
    tail_d      = tail_q;
    tail_last_d = tail_last_q;
    case (cnt_q)
      2'd0: begin
        if (rd_vld_q) begin
          head_d      = rd_data_q;
          head_last_d = rd_last_q;
          cnt_d       = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (rd_vld_q && pop_s) begin
          head_d      = rd_data_q;
          head_last_d = rd_last_q;
        end else if (rd_vld_q) begin
          tail_d      = rd_data_q;
          tail_last_d = rd_last_q;
          cnt_d       = 2'd2;
        end else if (pop_s) begin
          // keep out_last low while nothing is valid
          head_last_d = 1'b0;
          cnt_d       = 2'd0;
        end else begin
          cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_d      = tail_q;
          head_last_d = tail_last_q;
          if (rd_vld_q) begin
            tail_d      = rd_data_q;
            tail_last_d = rd_last_q;
          end else begin
            cnt_d = 2'd1;
          end
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Storage: write port (blocked by reset) and read-first registered read
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (issue_s) begin
      rd_data_q <= mem_q[addr_q];
    end
  end

  // Control FSM, FIFO registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      iss_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= '0;
      head_last_q <= 1'b0;
      tail_q      <= '0;
      tail_last_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      rd_vld_q    <= issue_s;
      rd_last_q   <= issue_s & last_iss_s;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      head_last_q <= head_last_d;
      tail_q      <= tail_d;
      tail_last_q <= tail_last_d;
      valid_q     <= (cnt_d != 2'd0);
      case (state_q)
        IDLE: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            addr_q   <= base;
            stride_q <= stride;
            len_q    <= len;
            iss_q    <= '0;
            if (len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            // flush: overrides the FIFO/in-flight updates made above
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            cnt_q       <= 2'd0;
            valid_q     <= 1'b0;
            head_last_q <= 1'b0;
          end else if (state_q == RUN) begin
            if (issue_s) begin
              addr_q <= addr_d;
              iss_q  <= iss_q + ONE_L;
              if (last_iss_s) begin
                state_q <= DRAIN;
              end
            end
          end else if (pop_s && head_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
